// File: rtl/mux_select_sequencer_pkg.sv
// Shared constants and types for the mux select sequencer.
// Channel index 0..3 maps to mux inputs a..d.
package mux_select_sequencer_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [SEL_W-1:0] CH_A = 2'd0;
  localparam logic [SEL_W-1:0] CH_B = 2'd1;
  localparam logic [SEL_W-1:0] CH_C = 2'd2;
  localparam logic [SEL_W-1:0] CH_D = 2'd3;

endpackage

// File: rtl/mux_select_sequencer_if.sv
// Control/status bundle between the sequencer and its controller.
// The master drives scan control; the slave drives the mux selects.
interface mux_select_sequencer_if #(
  parameter int DWELL_W = 4
);
  import mux_select_sequencer_pkg::*;

  logic               start;
  logic               stop;
  logic [NUM_CH-1:0]  en_mask;
  logic [DWELL_W-1:0] dwell;
  logic               s0;
  logic               s1;
  logic               sel_valid;
  logic               busy;
  logic               scan_done;

  modport master (
    output start, stop, en_mask, dwell,
    input  s0, s1, sel_valid, busy, scan_done
  );

  modport slave (
    input  start, stop, en_mask, dwell,
    output s0, s1, sel_valid, busy, scan_done
  );

endinterface

// File: rtl/mux_select_sequencer_rr_next_channel.sv
// Next enabled channel strictly above idx, wrapping through 0.
// With idx = 3 this yields the lowest enabled channel.
module rr_next_channel
  import mux_select_sequencer_pkg::*;
(
  input  logic [SEL_W-1:0]  idx,
  input  logic [NUM_CH-1:0] mask,
  output logic [SEL_W-1:0]  nxt,
  output logic              wrapped,
  output logic              none
);

  logic           found;
  logic [SEL_W:0] sum;

  always_comb begin
    nxt     = idx;
    wrapped = 1'b0;
    found   = 1'b0;
    sum     = '0;
    none    = (mask == '0);
    // carry out of the index add marks a pass boundary
    for (int k = 1; k <= NUM_CH; k++) begin
      sum = {1'b0, idx} + (SEL_W+1)'(k);
      if (!found && mask[sum[SEL_W-1:0]]) begin
        found   = 1'b1;
        nxt     = sum[SEL_W-1:0];
        wrapped = sum[SEL_W];
      end
    end
  end

endmodule

// File: rtl/mux_select_sequencer.sv
// Round-robin select generator for a 4:1 mux built from 2:1 stages.
// Holds each enabled channel for dwell+1 cycles; all outputs registered.
module mux_select_sequencer
  import mux_select_sequencer_pkg::*;
#(
  parameter int DWELL_W = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  mux_select_sequencer_if.slave bus
);

  state_t             state;
  logic [DWELL_W-1:0] cnt;
  logic [SEL_W-1:0]   sel;
  logic [SEL_W-1:0]   look_idx;
  logic [SEL_W-1:0]   nxt;
  logic               wrapped;
  logic               none;
  logic               sel_valid;
  logic               busy;
  logic               scan_done;

  // one search block serves both start lookup and advance
  assign look_idx = (state == IDLE) ? CH_D : sel;

  rr_next_channel u_next (
    .idx     (look_idx),
    .mask    (bus.en_mask),
    .nxt     (nxt),
    .wrapped (wrapped),
    .none    (none)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      sel       <= CH_A;
      sel_valid <= 1'b0;
      busy      <= 1'b0;
      scan_done <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          scan_done <= 1'b0;
          if (bus.start && !bus.stop && !none) begin
            state     <= HOLD;
            sel       <= nxt;
            cnt       <= bus.dwell;
            sel_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.stop || (cnt == '0 && none)) begin
            state     <= IDLE;
            sel_valid <= 1'b0;
            busy      <= 1'b0;
            scan_done <= 1'b0;
          end else if (cnt != '0) begin
            cnt       <= cnt - 1'b1;
            scan_done <= 1'b0;
          end else begin
            sel       <= nxt;
            cnt       <= bus.dwell;
            scan_done <= wrapped;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.s1        = sel[1];
  assign bus.s0        = sel[0];
  assign bus.sel_valid = sel_valid;
  assign bus.busy      = busy;
  assign bus.scan_done = scan_done;

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic
// against a behavioural scan model.
module tb_mux_select_sequencer;

  logic clk;
  logic rst_n;

  mux_select_sequencer_if #(.DWELL_W(4)) bus ();

  mux_select_sequencer #(.DWELL_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 4:1 mux from 2:1 stages, data a=1 b=0 c=1 d=0
  logic mux_a, mux_b, mux_c, mux_d, m0, m1, z;
  assign mux_a = 1'b1;
  assign mux_b = 1'b0;
  assign mux_c = 1'b1;
  assign mux_d = 1'b0;
  assign m0 = bus.s0 ? mux_b : mux_a;
  assign m1 = bus.s0 ? mux_d : mux_c;
  assign z  = bus.s1 ? m1 : m0;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit       m_busy;
  bit       m_valid;
  bit       m_done;
  int       m_sel;
  int       m_left;

  logic [4:0] got;
  logic [4:0] exp;

  function automatic int lowest(input logic [3:0] msk);
    for (int i = 0; i < 4; i++)
      if (msk[i]) return i;
    return -1;
  endfunction

  function automatic int higher(input logic [3:0] msk, input int cur);
    for (int i = cur + 1; i < 4; i++)
      if (msk[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_valid = 0; m_done = 0;
    m_sel = 0; m_left = 0;
  endtask

  task automatic model_edge(input bit st, input bit sp,
                            input logic [3:0] msk, input int dw);
    int h;
    if (!m_busy) begin
      m_done = 0;
      if (st && !sp && msk != 0) begin
        m_busy = 1; m_valid = 1;
        m_sel = lowest(msk); m_left = dw;
      end
    end else if (sp || (m_left == 0 && msk == 0)) begin
      m_busy = 0; m_valid = 0; m_done = 0;
    end else if (m_left > 0) begin
      m_left--; m_done = 0;
    end else begin
      h = higher(msk, m_sel);
      m_done = (h < 0);
      m_sel = (h < 0) ? lowest(msk) : h;
      m_left = dw;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(bus.start, bus.stop, bus.en_mask, int'(bus.dwell));
    @(negedge clk);
    got = {bus.s1, bus.s0, bus.sel_valid, bus.busy, bus.scan_done};
    exp = {2'(m_sel), m_valid, m_busy, m_done};
  endtask

  task automatic go_idle();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 0; bus.stop = 0; bus.en_mask = 0; bus.dwell = 0;
    model_reset();
    #12;
    got = {bus.s1, bus.s0, bus.sel_valid, bus.busy, bus.scan_done};
    checks++;
    if (got !== 5'b0) begin
      errors++;
      $display("FAIL reset: got %b want 00000", got);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_idle: got %b want %b", got, exp);
    end
  endtask

  task automatic test_rr_full();
    logic [3:0] data;
    data = {mux_d, mux_c, mux_b, mux_a};
    bus.en_mask = 4'b1111; bus.dwell = 0; bus.start = 1;
    tick();
    bus.start = 0;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL rr_full cyc%0d: got %b want %b", i, got, exp);
      end
      checks++;
      if (z !== data[m_sel]) begin
        errors++;
        $display("FAIL mux_z cyc%0d: got %b want %b", i, z, data[m_sel]);
      end
      tick();
    end
    go_idle();
  endtask

  task automatic test_sparse();
    bus.en_mask = 4'b1010; bus.dwell = 2; bus.start = 1;
    tick();
    bus.start = 0;
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL sparse cyc%0d: got %b want %b", i, got, exp);
      end
      tick();
    end
    go_idle();
  endtask

  task automatic test_single();
    bus.en_mask = 4'b0100; bus.dwell = 1; bus.start = 1;
    tick();
    bus.start = 0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL single cyc%0d: got %b want %b", i, got, exp);
      end
      tick();
    end
    go_idle();
  endtask

  task automatic test_stop();
    bus.en_mask = 4'b1010; bus.dwell = 4;
    bus.start = 1; bus.stop = 1;
    tick();
    bus.start = 0; bus.stop = 0;
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL start_stop: got %b want %b", got, exp);
    end
    bus.start = 1;
    tick();
    bus.start = 0;
    tick();
    bus.stop = 1;
    tick();
    bus.stop = 0;
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL stop_mid: got %b want %b", got, exp);
    end
  endtask

  task automatic test_mask_zero();
    bus.en_mask = 4'b1111; bus.dwell = 3; bus.start = 1;
    tick();
    bus.start = 0;
    tick();
    bus.en_mask = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL mask_zero cyc%0d: got %b want %b", i, got, exp);
      end
    end
    bus.start = 1;
    tick();
    bus.start = 0;
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL start_nomask: got %b want %b", got, exp);
    end
  endtask

  task automatic test_async_reset();
    bus.en_mask = 4'b1000; bus.dwell = 6; bus.start = 1;
    tick();
    bus.start = 0;
    tick();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL pre_reset: got %b want %b", got, exp);
    end
    @(posedge clk);
    model_edge(bus.start, bus.stop, bus.en_mask, int'(bus.dwell));
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    got = {bus.s1, bus.s0, bus.sel_valid, bus.busy, bus.scan_done};
    checks++;
    if (got !== 5'b0) begin
      errors++;
      $display("FAIL async_reset: got %b want 00000", got);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.start = ($urandom_range(0, 3) == 0);
      bus.stop  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0)
        bus.en_mask = 4'($urandom_range(0, 15));
      bus.dwell = 4'($urandom_range(0, 3));
      tick();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random cyc%0d: got %b want %b", i, got, exp);
      end
    end
    bus.start = 0; bus.stop = 0;
  endtask

  initial begin
    test_reset();
    test_rr_full();
    test_sparse();
    test_single();
    test_stop();
    test_mask_zero();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
